// File: rtl/chunked_adder_pipe.sv
// Multi-cycle add/subtract unit: adds CHUNK bits per clock, LSB chunk first,
// with a registered inter-chunk carry and valid/ready handshakes on both sides.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready=1
// RUN    | one chunk added per clock, cnt selects the chunk
// DONE   | result held until out_ready
module chunked_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             cy;
  logic             last_chunk;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_comb begin
    a_chunk    = a_q[cnt*CHUNK +: CHUNK];
    b_chunk    = b_q[cnt*CHUNK +: CHUNK];
    {cy, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    last_chunk = (cnt == CW'(NCHUNK - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? ~c_in : c_in;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum[cnt*CHUNK +: CHUNK] <= s_chunk;
          carry <= cy;
          if (last_chunk) begin
            c_out <= cy;
            // same-sign operands giving an opposite-sign result == carry-in XOR carry-out at the MSB
            ovf   <= (a_chunk[CHUNK-1] == b_chunk[CHUNK-1]) &&
                     (s_chunk[CHUNK-1] != a_chunk[CHUNK-1]);
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
